sec_frame_seq: RTL and testbench
================================

Name: sec_frame_seq

Overview:
- Control FSM that sequences one frame through the security pipeline: FIFO stage → LIFO stage → user-key XOR → output LIFO.
- Generates the wr1/rd1, wr2/rd2 and wr3/rd3 strobes for those stages, counts words, and raises a done or error status.
- Sits beside the security datapath and drives only its control pins; it never touches data.

Parameters:
- DEPTH, 16, maximum words per frame; must equal the buffer depth of every stage.
- LW, 5, width of frame_len and of the internal counters; must satisfy 2^LW > DEPTH.
- TMO, 255, idle-cycle limit for the watchdog (used only when the watchdog macro is defined).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- start  in  1  one-cycle pulse; starts a frame, sampled only in IDLE.
- frame_len  in  LW  words in the frame; captured on start.
- in_valid  in  1  upstream word present on the datapath input.
- in_ready  out  1  high in FILL; a word is accepted when in_valid && in_ready.
- out_ready  in  1  downstream can take a word.
- out_valid  out  1  data_out_final is valid this cycle.
- fifo_full, fifo_empty  in  1  status from the FIFO stage.
- lifo_ov, lifo_ud  in  1  overflow/underflow flags from either LIFO (ORed externally).
- wr1, rd1, wr2, rd2, wr3, rd3  out  1  stage strobes.
- busy  out  1  high in any state except IDLE.
- done  out  1  one-cycle pulse when a frame completes cleanly.
- err  out  1  sticky; high in ERR.

Behaviour:
- Reset (rst_n=0 at a clk edge): state=IDLE, all strobes=0, in_ready=0, out_valid=0, busy=0, done=0, err=0, counters=0. Reset mid-frame aborts immediately; no further strobes are issued.
- Read data from every stage is valid one cycle after its rd strobe.
- States and transitions:
  - IDLE: on start with frame_len in 1..DEPTH → capture len, go to FILL. On start with frame_len==0 or frame_len>DEPTH → ERR. Otherwise stay.
  - FILL: in_ready=1; wr1 = in_valid && !fifo_full. Count increments on each accepted word. When count reaches len → clear count, go to XFER. If in_valid && fifo_full → ERR.
  - XFER: rd1=1 for len consecutive cycles. wr2 is rd1 delayed by one cycle (exactly len wr2 pulses). After the last wr2 → REV. If rd1 would be issued while fifo_empty → ERR.
  - REV: rd2=1 for len cycles; wr3 is rd2 delayed by one cycle, so the key XOR sits between rd2 and wr3 with no added register. After the last wr3 → DRAIN.
  - DRAIN: rd3 = out_ready && (remaining>0). out_valid is rd3 delayed by one cycle. When out_ready is low, no rd3 is issued and the pipeline holds. After the last out_valid → DONE.
  - DONE: done=1 for one cycle → IDLE.
  - ERR: err=1, all strobes=0. Leave ERR only on reset, or on start with a legal frame_len, which clears err and goes to FILL.
- Any lifo_ov or lifo_ud in any state other than IDLE → ERR on the next edge.
- start while busy is ignored.
- Minimum frame latency with in_valid and out_ready held high: start to done is len+1 (FILL) + len+1 (XFER) + len+1 (REV) + len+1 (DRAIN) + 1 cycles, i.e. 4·len+5.
- At no time may two stages write the same buffer in one cycle, and no stage may be read and written in the same cycle.

Optional Feature:
- Macro SEC_FRAME_TIMEOUT_EN.
- Defined: a watchdog counts consecutive cycles in FILL with in_valid=0, and in DRAIN with out_ready=0. The counter clears whenever progress is made. When it reaches TMO → ERR.
- Undefined: no watchdog logic is built, TMO is unused, and FILL/DRAIN wait indefinitely.

Test Plan:
- Reset, then start with frame_len=4, in_valid and out_ready held at 1 → 4 wr1, 4 rd1, 4 wr2, 4 rd2, 4 wr3, 4 rd3, 4 out_valid; done pulses exactly 21 cycles after start; err=0.
- frame_len=16 with out_ready toggling 1,0,1,0 in DRAIN → 16 out_valid, each one cycle after a rd3; no rd3 while out_ready=0; done once.
- start with frame_len=0, then with frame_len=17 → err=1 next cycle, no strobes. A following start with frame_len=2 clears err and completes.
- Force lifo_ov=1 for one cycle mid-REV (frame_len=8) → ERR next edge, all strobes 0 from then on, busy stays 1.
- rst_n=0 for one edge during XFER of an 8-word frame → all outputs 0 next cycle, state IDLE; a new start with frame_len=3 completes in 17 cycles.
- With SEC_FRAME_TIMEOUT_EN and TMO=10: hold in_valid=0 in FILL → err=1 after exactly 10 idle cycles. Without the macro → still in FILL after 1000 cycles.

Source files
------------

// File: rtl/sec_frame_seq.sv
`default_nettype none
// ============================================================================
//  Module   : sec_frame_seq
//  Purpose  : Control sequencer for one frame through the security pipeline:
//             FIFO stage -> LIFO stage -> user-key XOR -> output LIFO.
//             Issues the stage read/write strobes, counts words, and reports
//             done / error status. It never touches the data path itself.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Parameters
//    DEPTH  maximum words per frame (equals every stage's buffer depth)
//    LW     width of frame_len and the word counter, 2**LW > DEPTH
//    TMO    watchdog idle-cycle limit (only with SEC_FRAME_TIMEOUT_EN)
//  Ports
//    clk, rst_n             clock (rising edge), synchronous active-low reset
//    start, frame_len       frame request and its length, sampled when idle/err
//    in_valid / in_ready    upstream handshake, words accepted in FILL
//    out_ready / out_valid  downstream handshake for data_out_final
//    fifo_full, fifo_empty  FIFO stage status
//    lifo_ov, lifo_ud       ORed overflow / underflow of both LIFOs
//    wr1..rd3               stage strobes (FIFO, LIFO, output LIFO)
//    busy, done, err        status: not idle, frame complete pulse, error
//  Configuration
//    SEC_FRAME_TIMEOUT_EN   when defined, a watchdog forces ERR after TMO
//                           consecutive stalled cycles in FILL or DRAIN.
// ============================================================================
module sec_frame_seq #(
    parameter int DEPTH = 16,
    parameter int LW    = 5,
    parameter int TMO   = 255
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [LW-1:0] frame_len,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic          out_ready,
    output logic          out_valid,
    input  logic          fifo_full,
    input  logic          fifo_empty,
    input  logic          lifo_ov,
    input  logic          lifo_ud,
    output logic          wr1,
    output logic          rd1,
    output logic          wr2,
    output logic          rd2,
    output logic          wr3,
    output logic          rd3,
    output logic          busy,
    output logic          done,
    output logic          err
);

    // ------------------------------------------------------------------
    // Elaboration-time parameter sanity
    // ------------------------------------------------------------------
    if ((2 ** LW) <= DEPTH) begin : g_bad_lw
        $error("sec_frame_seq: LW too narrow to hold DEPTH");
    end
    if (TMO < 1) begin : g_bad_tmo
        $error("sec_frame_seq: TMO must be at least 1");
    end

    localparam logic [LW-1:0] c_depth = LW'(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FILL  = 3'd1,
        S_XFER  = 3'd2,
        S_REV   = 3'd3,
        S_DRAIN = 3'd4,
        S_DONE  = 3'd5,
        S_ERR   = 3'd6
    } state_t;

    state_t        state_q, state_d;
    logic [LW-1:0] len_q, len_d;
    logic [LW-1:0] cnt_q, cnt_d;
    logic          wr2_q, wr2_d;
    logic          wr3_q, wr3_d;
    logic          out_valid_q, out_valid_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          err_q, err_d;

    logic          w_len_ok;
    logic          w_cnt_lt;
    logic          w_lifo_err;
    logic          w_wr1;
    logic          w_rd1;
    logic          w_rd2;
    logic          w_rd3;
    logic          w_in_ready;
    logic          w_wdog_hit;

    // ------------------------------------------------------------------
    // Immediate strobes.
    // These are decoded from the registered state and word counter. wr1
    // and rd3 must follow the same-cycle handshake inputs, and rd1 must be
    // withheld in the very cycle the FIFO reports empty, so they cannot be
    // pure flops. The one-cycle-delayed strobes are registered below.
    // ------------------------------------------------------------------
    always_comb begin
        w_len_ok   = (frame_len != '0) && (frame_len <= c_depth);
        w_cnt_lt   = (cnt_q < len_q);
        w_lifo_err = (state_q != S_IDLE) && (lifo_ov || lifo_ud);
        // The turnover cycle (count == len) still sits in FILL but must not
        // take an extra word, so in_ready drops there.
        w_in_ready = (state_q == S_FILL) && w_cnt_lt;
        w_wr1      = w_in_ready && in_valid && !fifo_full;
        w_rd1      = (state_q == S_XFER)  && w_cnt_lt && !fifo_empty;
        w_rd2      = (state_q == S_REV)   && w_cnt_lt;
        w_rd3      = (state_q == S_DRAIN) && w_cnt_lt && out_ready;
    end

    // ------------------------------------------------------------------
    // Optional watchdog: counts consecutive stalled cycles while waiting
    // on upstream (FILL) or downstream (DRAIN).
    // ------------------------------------------------------------------
`ifdef SEC_FRAME_TIMEOUT_EN
    localparam int TW = (TMO > 1) ? $clog2(TMO + 1) : 1;
    localparam logic [TW-1:0] c_tmo_m1 = TW'(TMO - 1);

    logic [TW-1:0] wdog_q, wdog_d;
    logic          w_stall;

    always_comb begin
        w_stall    = ((state_q == S_FILL)  && w_cnt_lt && !in_valid) ||
                     ((state_q == S_DRAIN) && w_cnt_lt && !out_ready);
        wdog_d     = w_stall ? (wdog_q + 1'b1) : '0;
        // Fires at the end of the TMO-th consecutive stalled cycle.
        w_wdog_hit = w_stall && (wdog_q == c_tmo_m1);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wdog_q <= '0;
        end else begin
            wdog_q <= wdog_d;
        end
    end
`else
    always_comb begin
        w_wdog_hit = 1'b0;
    end
`endif

    // ------------------------------------------------------------------
    // Next-state and counter logic. The single counter is reused per
    // phase: accepted words in FILL, reads issued in XFER/REV/DRAIN. Each
    // phase ends on the cycle the counter equals len, which is also the
    // cycle its delayed write (or out_valid) lands.
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        cnt_d   = cnt_q;

        unique case (state_q)
            S_IDLE, S_ERR: begin
                if (start) begin
                    if (w_len_ok) begin
                        len_d   = frame_len;
                        cnt_d   = '0;
                        state_d = S_FILL;
                    end else begin
                        state_d = S_ERR;
                    end
                end
            end
            S_FILL: begin
                if (!w_cnt_lt) begin
                    cnt_d   = '0;
                    state_d = S_XFER;
                end else if (in_valid && fifo_full) begin
                    state_d = S_ERR;
                end else if (w_wr1) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_XFER: begin
                if (!w_cnt_lt) begin
                    cnt_d   = '0;
                    state_d = S_REV;
                end else if (fifo_empty) begin
                    state_d = S_ERR;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_REV: begin
                if (!w_cnt_lt) begin
                    cnt_d   = '0;
                    state_d = S_DRAIN;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DRAIN: begin
                if (!w_cnt_lt) begin
                    cnt_d   = '0;
                    state_d = S_DONE;
                end else if (w_rd3) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Asynchronous-to-the-flow faults override whatever the phase chose.
        if (w_wdog_hit || w_lifo_err) begin
            state_d = S_ERR;
        end
        if ((state_d == S_ERR) && (state_q != S_ERR)) begin
            cnt_d = '0;
        end

        // Delayed strobes are suppressed when heading into ERR so nothing
        // is issued once the error is registered.
        wr2_d       = w_rd1 && (state_d != S_ERR);
        wr3_d       = w_rd2 && (state_d != S_ERR);
        out_valid_d = w_rd3 && (state_d != S_ERR);

        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
        err_d  = (state_d == S_ERR);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            len_q       <= '0;
            cnt_q       <= '0;
            wr2_q       <= 1'b0;
            wr3_q       <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            cnt_q       <= cnt_d;
            wr2_q       <= wr2_d;
            wr3_q       <= wr3_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign in_ready  = w_in_ready;
    assign wr1       = w_wr1;
    assign rd1       = w_rd1;
    assign wr2       = wr2_q;
    assign rd2       = w_rd2;
    assign wr3       = wr3_q;
    assign rd3       = w_rd3;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule
`default_nettype wire

// File: tb/tb_sec_frame_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sec_frame_seq
//  Purpose  : Self-checking bench for sec_frame_seq. Legal/illegal start
//             table, hand-written corner sequences, and random frames
//             compared against a cycle-position model of the frame phases.
//  Revision : 1.0  initial release
// ============================================================================
module tb_sec_frame_seq;

    localparam int DEPTH = 16;
    localparam int LW    = 5;
    localparam int MAXC  = 400;
`ifdef SEC_FRAME_TIMEOUT_EN
    localparam int TMO = 10;
`else
    localparam int TMO = 255;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [LW-1:0] frame_len = '0;
    logic          in_valid = 1'b0;
    logic          out_ready = 1'b0;
    logic          fifo_full = 1'b0;
    logic          fifo_empty = 1'b0;
    logic          lifo_ov = 1'b0;
    logic          lifo_ud = 1'b0;
    logic          in_ready, out_valid, wr1, rd1, wr2, rd2, wr3, rd3;
    logic          busy, done, err;

    sec_frame_seq #(.DEPTH(DEPTH), .LW(LW), .TMO(TMO)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .frame_len(frame_len),
        .in_valid(in_valid), .in_ready(in_ready),
        .out_ready(out_ready), .out_valid(out_valid),
        .fifo_full(fifo_full), .fifo_empty(fifo_empty),
        .lifo_ov(lifo_ov), .lifo_ud(lifo_ud),
        .wr1(wr1), .rd1(rd1), .wr2(wr2), .rd2(rd2), .wr3(wr3), .rd3(rd3),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Stimulus sequences (index = cycle offset from start) and model output.
    bit iv_seq [MAXC];
    bit or_seq [MAXC];
    bit e_wr1 [MAXC];
    bit e_rd1 [MAXC];
    bit e_rd2 [MAXC];
    bit e_rd3 [MAXC];

    typedef struct {
        logic [LW-1:0] len;
        logic [2:0]    exp_eb;   // {err, busy, in_ready} one cycle after start
    } vec_t;
    vec_t vtab [6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [10:0] all_outs();
        return {in_ready, out_valid, wr1, rd1, wr2, rd2, wr3, rd3, busy, done, err};
    endfunction

    function automatic logic [6:0] strobes();
        return {wr1, rd1, wr2, rd2, wr3, rd3, out_valid};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        lifo_ov = 1'b0; lifo_ud = 1'b0;
        step();
        rst_n = 1'b1;
        #2;
        check("reset_outputs", all_outs(), 0);
    endtask

    task automatic fill_seqs(input bit all_ones);
        int run;
        run = 0;
        for (int k = 0; k < MAXC; k++) begin
            iv_seq[k] = 1'b1;
            or_seq[k] = 1'b1;
        end
        if (!all_ones) begin
            for (int k = 1; k < 200; k++) begin
                if ($urandom_range(0, 2) == 0 && run < 3) begin
                    iv_seq[k] = 1'b0;
                    run++;
                end else begin
                    run = 0;
                end
            end
            run = 0;
            for (int k = 1; k < 200; k++) begin
                if ($urandom_range(0, 2) == 0 && run < 3) begin
                    or_seq[k] = 1'b0;
                    run++;
                end else begin
                    run = 0;
                end
            end
        end
    endtask

    // Runs one frame starting now (cycle 0 carries start) and compares every
    // strobe against the phase-position model derived from the handshakes.
    task automatic run_frame(input int len, input string tag, output int got_done);
        int acc, a_len, d0, rc, r_len, exp_done;
        int m_wr1, m_rd1, m_wr2, m_rd2, m_wr3, m_rd3, m_ov, m_stat;
        for (int k = 0; k < MAXC; k++) begin
            e_wr1[k] = 0; e_rd1[k] = 0; e_rd2[k] = 0; e_rd3[k] = 0;
        end
        acc = 0; a_len = 0;
        for (int k = 1; k < MAXC; k++) begin
            if (iv_seq[k] && acc < len) begin
                e_wr1[k] = 1;
                acc++;
                if (acc == len) a_len = k;
            end
        end
        for (int j = 0; j < len; j++) begin
            e_rd1[a_len + 2 + j]       = 1;
            e_rd2[a_len + len + 3 + j] = 1;
        end
        d0 = a_len + 2 * len + 4;
        rc = 0; r_len = 0;
        for (int k = d0; k < MAXC; k++) begin
            if (or_seq[k] && rc < len) begin
                e_rd3[k] = 1;
                rc++;
                if (rc == len) r_len = k;
            end
        end
        exp_done = r_len + 2;

        m_wr1 = 0; m_rd1 = 0; m_wr2 = 0; m_rd2 = 0; m_wr3 = 0; m_rd3 = 0;
        m_ov = 0; m_stat = 0;
        got_done = -1;
        for (int k = 0; k < MAXC; k++) begin
            if (k == 0) begin
                start = 1'b1;
                frame_len = LW'(len);
            end else begin
                // Stray starts while busy must be ignored.
                start = ($urandom_range(0, 7) == 0);
                frame_len = LW'($urandom);
            end
            in_valid  = iv_seq[k];
            out_ready = or_seq[k];
            #2;
            if (wr1 !== e_wr1[k]) m_wr1++;
            if (rd1 !== e_rd1[k]) m_rd1++;
            if (rd2 !== e_rd2[k]) m_rd2++;
            if (rd3 !== e_rd3[k]) m_rd3++;
            if (wr2 !== ((k > 0) && e_rd1[k-1])) m_wr2++;
            if (wr3 !== ((k > 0) && e_rd2[k-1])) m_wr3++;
            if (out_valid !== ((k > 0) && e_rd3[k-1])) m_ov++;
            if (k >= 1 && (err !== 1'b0 || busy !== 1'b1)) m_stat++;
            if (done === 1'b1) begin
                got_done = k;
                step();
                break;
            end
            step();
        end
        start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        #2;
        check({tag, "_done_cycle"}, got_done, exp_done);
        check({tag, "_wr1"}, m_wr1, 0);
        check({tag, "_rd1"}, m_rd1, 0);
        check({tag, "_wr2"}, m_wr2, 0);
        check({tag, "_rd2"}, m_rd2, 0);
        check({tag, "_wr3"}, m_wr3, 0);
        check({tag, "_rd3"}, m_rd3, 0);
        check({tag, "_out_valid"}, m_ov, 0);
        check({tag, "_status"}, m_stat, 0);
        check({tag, "_idle_after"}, {busy, done, err}, 0);
    endtask

    initial begin
        int got;
        int bad;

        vtab[0] = '{len: 5'd0,  exp_eb: 3'b110};
        vtab[1] = '{len: 5'd17, exp_eb: 3'b110};
        vtab[2] = '{len: 5'd31, exp_eb: 3'b110};
        vtab[3] = '{len: 5'd1,  exp_eb: 3'b011};
        vtab[4] = '{len: 5'd16, exp_eb: 3'b011};
        vtab[5] = '{len: 5'd9,  exp_eb: 3'b011};

        step();
        do_reset();

        // Start legality table.
        for (int i = 0; i < 6; i++) begin
            do_reset();
            start = 1'b1;
            frame_len = vtab[i].len;
            #2;
            step();
            start = 1'b0;
            #2;
            check($sformatf("start_len_%0d", vtab[i].len), {err, busy, in_ready}, vtab[i].exp_eb);
        end

        // Nominal frame, len=4, everything always ready.
        do_reset();
        fill_seqs(1'b1);
        run_frame(4, "len4", got);
        check("len4_latency_21", got, 21);

        // len=16, out_ready alternating 1,0 from the start of DRAIN.
        fill_seqs(1'b1);
        for (int k = 3 * 16 + 4; k < MAXC; k++) or_seq[k] = ((k - (3 * 16 + 4)) % 2 == 0);
        run_frame(16, "len16_toggle", got);

        // Illegal starts then a legal one out of ERR.
        do_reset();
        start = 1'b1; frame_len = 5'd0;
        #2; step(); start = 1'b0; #2;
        check("len0_err", {err, busy}, 2'b11);
        check("len0_strobes", strobes(), 0);
        start = 1'b1; frame_len = 5'd17;
        #2; step(); start = 1'b0; #2;
        check("len17_err", {err, busy}, 2'b11);
        check("len17_strobes", strobes(), 0);
        fill_seqs(1'b1);
        run_frame(2, "recover_len2", got);

        // lifo_ov pulse mid-REV of an 8-word frame (REV spans cycles 19..27).
        do_reset();
        start = 1'b1; frame_len = 5'd8; in_valid = 1'b1; out_ready = 1'b1;
        #2; step(); start = 1'b0;
        for (int k = 1; k <= 22; k++) begin
            lifo_ov = (k == 22);
            #2;
            if (k == 22) check("ov_mid_rev_rd2", rd2, 1);
            step();
        end
        lifo_ov = 1'b0;
        bad = 0;
        for (int k = 0; k < 20; k++) begin
            #2;
            if (strobes() !== 7'd0 || err !== 1'b1 || busy !== 1'b1 || in_ready !== 1'b0) bad++;
            step();
        end
        check("ov_err_hold", bad, 0);

        // Reset during XFER of an 8-word frame (rd1 on cycles 10..17).
        do_reset();
        start = 1'b1; frame_len = 5'd8; in_valid = 1'b1; out_ready = 1'b1;
        #2; step(); start = 1'b0;
        for (int k = 1; k <= 11; k++) begin
            #2; step();
        end
        rst_n = 1'b0;
        #2;
        check("xfer_rd1_before_rst", rd1, 1);
        step();
        rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        #2;
        check("midframe_rst_outputs", all_outs(), 0);
        fill_seqs(1'b1);
        run_frame(3, "after_rst_len3", got);
        check("len3_latency_17", got, 17);

        // Upstream stall in FILL.
        do_reset();
        start = 1'b1; frame_len = 5'd4; in_valid = 1'b0; out_ready = 1'b1;
        #2; step(); start = 1'b0;
`ifdef SEC_FRAME_TIMEOUT_EN
        for (int k = 1; k <= 11; k++) begin
            #2;
            if (k == 10) check("wdog_err_before", err, 0);
            if (k == 11) check("wdog_err_after", err, 1);
            step();
        end
`else
        for (int k = 1; k <= 1000; k++) begin
            #2; step();
        end
        #2;
        check("fill_wait_1000", {in_ready, busy, err}, 3'b110);
`endif

        // Random frames against the model.
        do_reset();
        for (int f = 0; f < 12; f++) begin
            fill_seqs(1'b0);
            run_frame(int'($urandom_range(1, DEPTH)), $sformatf("rand%0d", f), got);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
